// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter (clk, reset, start, bin_in -> busy, done, bcd_out, ovf; blank when BCD_BLANK_EN is defined)
module bin_to_bcd_seq #(
  parameter int DATA_W = 32,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
`ifdef BCD_BLANK_EN
  , output logic [DIGITS-1:0]   blank
`endif
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(10 ** DIGITS - 1);
  state_t state;
  logic [DATA_W-1:0] sr;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-2:0] acc_adj;
  logic [CW-1:0] cnt;
  logic ovf_pending;
  assign busy = state != IDLE;
  always_comb begin
    acc_adj = acc[4*DIGITS-2:0];
    for (int i = 0; i < DIGITS - 1; i++)
      acc_adj[4*i +: 4] = acc[4*i +: 4] >= 4'd5 ? acc[4*i +: 4] + 4'd3 : acc[4*i +: 4];
    acc_adj[4*DIGITS-2 -: 3] = 3'(acc[4*DIGITS-1 -: 4] >= 4'd5 ? acc[4*DIGITS-1 -: 4] + 4'd3 : acc[4*DIGITS-1 -: 4]);
  end
`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] lz;
  logic z;
  always_comb begin
    lz = '0;
    z = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      z = z && acc[4*i +: 4] == 4'd0;
      lz[i] = z;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done <= 1'b0;
      bcd_out <= '0;
      ovf <= 1'b0;
      sr <= '0;
      acc <= '0;
      cnt <= '0;
      ovf_pending <= 1'b0;
`ifdef BCD_BLANK_EN
      blank <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sr <= bin_in;
          acc <= '0;
          cnt <= CW'(DATA_W);
          ovf_pending <= bin_in > MAX_VAL;
          state <= SHIFT;
        end
        SHIFT: begin
          acc <= {acc_adj, sr[DATA_W-1]};
          sr <= {sr[DATA_W-2:0], 1'b0};
          cnt <= cnt - 1'b1;
          state <= cnt == CW'(1) ? DONE : SHIFT;
        end
        DONE: begin
          bcd_out <= ovf_pending ? {DIGITS{4'h9}} : acc;
          ovf <= ovf_pending;
          done <= 1'b1;
`ifdef BCD_BLANK_EN
          blank <= ovf_pending ? '0 : lz;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for bin_to_bcd_seq against a decimal-arithmetic reference model
module tb_bin_to_bcd_seq;
  logic clk = 0, reset = 1, start = 0;
  logic [31:0] bin_in = 0;
  logic busy, done, ovf;
  logic [15:0] bcd_out;
`ifdef BCD_BLANK_EN
  logic [3:0] blank;
`endif
  int checks = 0, errors = 0;
  longint cyc = 0;
  logic [15:0] held = 0;
  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
  } exp_t;
  exp_t q[$];
  bin_to_bcd_seq #(.DATA_W(32), .DIGITS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
`ifdef BCD_BLANK_EN
    , .blank(blank)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic exp_t model(logic [31:0] v);
    exp_t e;
    longint unsigned n, p;
    e.ovf = v > 32'd9999;
    n = e.ovf ? 64'd9999 : 64'(v);
    p = 1;
    for (int i = 0; i < 4; i++) begin
      e.bcd[4*i +: 4] = 4'((n / p) % 10);
      e.blank[i] = i > 0 && !e.ovf && (n / p) == 0;
      p = p * 10;
    end
    return e;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp_v);
    end
  endtask
  always @(negedge clk) begin
    if (reset) held = 0;
    else if (done) begin
      if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
        chk("ovf", 32'(ovf), 32'(e.ovf));
`ifdef BCD_BLANK_EN
        chk("blank", 32'(blank), 32'(e.blank));
`endif
        held = e.bcd;
      end
    end else if (busy) chk("hold_bcd", 32'(bcd_out), 32'(held));
  end
  task automatic go(logic [31:0] v, int glitch_at, output longint done_at);
    int j, bn;
    bin_in = v;
    start = 1;
    q.push_back(model(v));
    bn = 0;
    done_at = -1;
    for (j = 1; j <= 60; j++) begin
      @(negedge clk);
      if (j == 1) begin
        start = 0;
        bin_in = $urandom;
      end
      if (glitch_at > 0 && j == glitch_at) begin
        start = 1;
        bin_in = 42;
      end
      if (glitch_at > 0 && j == glitch_at + 1) start = 0;
      if (busy) bn++;
      if (done) begin
        done_at = cyc;
        break;
      end
    end
    chk("latency", 32'(j), 32'd34);
    chk("busy_cycles", 32'(bn), 32'd33);
  endtask
  initial begin
    longint d, prev;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_bcd", 32'(bcd_out), 0);
    chk("rst_ovf", 32'(ovf), 0);
`ifdef BCD_BLANK_EN
    chk("rst_blank", 32'(blank), 0);
`endif
    reset = 0;
    @(negedge clk);
    go(0, 0, d);
    go(1234, 0, d);
    go(9999, 0, d);
    go(10000, 0, d);
    go(32'hFFFFFFFF, 0, d);
    go(7, 5, d);
    go(42, 0, d);
    go(56, 0, d);
    bin_in = 8765;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (10) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_bcd", 32'(bcd_out), 0);
    chk("abort_ovf", 32'(ovf), 0);
    repeat (40) @(negedge clk);
    go(305, 0, d);
    prev = d;
    for (int i = 0; i < 1000; i++) begin
      go($urandom_range(12000, 0), 0, d);
      chk("done_spacing", 32'(d - prev), 32'd34);
      prev = d;
    end
    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
